// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// opcode match constants, ALU control encodings and the opcode class type.
package multicycle_control_pkg;

  // Controller states; 4 bits leaves room for the unused codes to recover to FETCH.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EX_R    = 4'd2,
    EX_ADDR = 4'd3,
    MEM_RD  = 4'd4,
    MEM_WR  = 4'd5,
    WB_R    = 4'd6,
    WB_LD   = 4'd7,
    BR      = 4'd8,
    TRAP    = 4'd9
  } ctrlState_t;

  // ALU operation select.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_PASSB = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluOp_t;

  // ALU operand B select.
  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_BROFF = 2'b11
  } aluSrcB_t;

  // Opcode patterns (IR[31:21]); CBZ ignores its low three bits.
  localparam logic [10:0] OP_CBZ      = 11'b10110100000;
  localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
  localparam logic [10:0] OP_LDUR     = 11'b11111000010;
  localparam logic [10:0] OP_STUR     = 11'b11111000000;
  localparam logic [10:0] OP_ADD      = 11'b10001011000;
  localparam logic [10:0] OP_SUB      = 11'b11001011000;
  localparam logic [10:0] OP_AND      = 11'b10001010000;
  localparam logic [10:0] OP_ORR      = 11'b10101010000;

  // One-hot instruction class.
  typedef struct packed {
    logic r;
    logic ld;
    logic st;
    logic cbz;
    logic ill;
  } opClass_t;

  // Masked opcode compare.
  function automatic logic opMatch(input logic [10:0] op,
                                   input logic [10:0] pattern,
                                   input logic [10:0] mask);
    return (op & mask) == (pattern & mask);
  endfunction

endpackage

// File: rtl/multicycle_control_op_class_decode.sv
// Combinational opcode classifier: maps the IR opcode field to a one-hot class.
module op_class_decode
  import multicycle_control_pkg::*;
(
  input  logic [10:0] op,
  output opClass_t    opClass
);

  // Priority match: CBZ, LDUR, STUR, R-format, everything else illegal.
  // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
  always_comb begin
    opClass = '0;
    if (opMatch(op, OP_CBZ, OP_CBZ_MASK)) begin
      opClass.cbz = 1'b1;
    end else if (op == OP_LDUR) begin
      opClass.ld = 1'b1;
    end else if (op == OP_STUR) begin
      opClass.st = 1'b1;
    end else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
      opClass.r = 1'b1;
    end else begin
      opClass.ill = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: sequences fetch/decode/execute/memory/
// write-back, drives datapath strobes and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             Reg2Loc,
  output logic             PCSrc,
  output logic             IorD,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  ctrlState_t state;
  opClass_t   opClass;

  op_class_decode uDecode (
    .op      (op),
    .opClass (opClass)
  );

  // State sequencing and retirement count; retiring states bump the count as they exit.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) state <= DECODE;
        end
        DECODE: begin
          if (opClass.r)                    state <= EX_R;
          else if (opClass.ld || opClass.st) state <= EX_ADDR;
          else if (opClass.cbz)             state <= BR;
          else                              state <= TRAP;
        end
        EX_R: begin
          state <= WB_R;
        end
        EX_ADDR: begin
          state <= opClass.st ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          if (mem_ready) state <= WB_LD;
        end
        MEM_WR: begin
          if (mem_ready) begin
            state   <= FETCH;
            retired <= retired + CNT_W'(1);
          end
        end
        WB_R, WB_LD, BR: begin
          state   <= FETCH;
          retired <= retired + CNT_W'(1);
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Halt flag follows the trap state directly.
  assign halted = (state == TRAP);

  // Datapath strobes decoded from state; suppressed entirely while reset is held.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    ALUOp    = ALUOP_ADD;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    Reg2Loc  = 1'b0;
    PCSrc    = 1'b0;
    IorD     = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          ALUSrcB = SRCB_FOUR;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB = SRCB_BROFF;
          Reg2Loc = opClass.cbz | opClass.st;
        end
        EX_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        EX_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        WB_R: begin
          RegWrite = 1'b1;
        end
        WB_LD: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        BR: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_PASSB;
          Reg2Loc = 1'b1;
          PCSrc   = 1'b1;
          PCWrite = zero;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: each cycle's expected strobes and
// retired count are queued when stimulus is applied and popped for comparison.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] ILL  = 11'b11111111111;

  // Expected strobe vectors: {PCWrite, IRWrite, ALUOp[1:0], ALUSrcA, ALUSrcB[1:0],
  // MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc, PCSrc, IorD, halted}
  localparam logic [14:0] E_NONE     = 15'b0_0_00_0_00_0_0_0_0_0_0_0_0;
  localparam logic [14:0] E_FETCH    = 15'b1_1_00_0_01_1_0_0_0_0_0_0_0;
  localparam logic [14:0] E_FETCH_WT = 15'b0_0_00_0_01_1_0_0_0_0_0_0_0;
  localparam logic [14:0] E_DEC      = 15'b0_0_00_0_11_0_0_0_0_0_0_0_0;
  localparam logic [14:0] E_DEC_R2L  = 15'b0_0_00_0_11_0_0_0_0_1_0_0_0;
  localparam logic [14:0] E_EXR      = 15'b0_0_10_1_00_0_0_0_0_0_0_0_0;
  localparam logic [14:0] E_EXADDR   = 15'b0_0_00_1_10_0_0_0_0_0_0_0_0;
  localparam logic [14:0] E_MEMRD    = 15'b0_0_00_0_00_1_0_0_0_0_0_1_0;
  localparam logic [14:0] E_MEMWR    = 15'b0_0_00_0_00_0_1_0_0_0_0_1_0;
  localparam logic [14:0] E_WBR      = 15'b0_0_00_0_00_0_0_1_0_0_0_0_0;
  localparam logic [14:0] E_WBLD     = 15'b0_0_00_0_00_0_0_1_1_0_0_0_0;
  localparam logic [14:0] E_BR_T     = 15'b1_0_01_1_00_0_0_0_0_1_1_0_0;
  localparam logic [14:0] E_BR_N     = 15'b0_0_01_1_00_0_0_0_0_1_1_0_0;
  localparam logic [14:0] E_TRAP     = 15'b0_0_00_0_00_0_0_0_0_0_0_0_1;

  logic             clk = 1'b0;
  logic             reset;
  logic [10:0]      op;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite, IRWrite, ALUSrcA, MemRead, MemWrite, RegWrite;
  logic             MemtoReg, Reg2Loc, PCSrc, IorD, halted;
  logic [1:0]       ALUOp, ALUSrcB;
  logic [CNT_W-1:0] retired;
  logic [14:0]      obsCtrl;

  typedef struct {
    string            tag;
    logic [14:0]      ctrl;
    logic [CNT_W-1:0] ret;
  } expect_t;

  expect_t sb[$];
  int      checks   = 0;
  int      failures = 0;
  int      expRet   = 0;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .IRWrite   (IRWrite),
    .ALUOp     (ALUOp),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .MemtoReg  (MemtoReg),
    .Reg2Loc   (Reg2Loc),
    .PCSrc     (PCSrc),
    .IorD      (IorD),
    .halted    (halted),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  assign obsCtrl = {PCWrite, IRWrite, ALUOp, ALUSrcA, ALUSrcB, MemRead, MemWrite,
                    RegWrite, MemtoReg, Reg2Loc, PCSrc, IorD, halted};

  // One clock cycle: apply inputs after the falling edge, queue the expectation,
  // then compare the settled outputs before the next rising edge.
  task automatic step(input string tag, input logic rst, input logic [10:0] o,
                      input logic z, input logic mr, input logic [14:0] e);
    expect_t x;
    expect_t got;
    @(negedge clk);
    reset     = rst;
    op        = o;
    zero      = z;
    mem_ready = mr;
    x.tag  = tag;
    x.ctrl = e;
    x.ret  = CNT_W'(expRet);
    sb.push_back(x);
    #1;
    got = sb.pop_front();
    checks++;
    assert (obsCtrl === got.ctrl) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b", got.tag, obsCtrl, got.ctrl);
    end
    checks++;
    assert (retired === got.ret) else begin
      failures++;
      $error("FAIL %s retired observed=%0d expected=%0d", got.tag, retired, got.ret);
    end
    checks++;
    assert (!(MemRead === 1'b1 && MemWrite === 1'b1)) else begin
      failures++;
      $error("FAIL %s memrw observed=%b%b expected=not both", got.tag, MemRead, MemWrite);
    end
  endtask

  initial begin
    reset     = 1'b1;
    op        = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;

    // Reset cycle: no strobes, counter cleared.
    step("reset", 1'b1, ADD, 1'b0, 1'b1, E_NONE);

    // ADD with one fetch wait state.
    step("add_fetch_wait", 1'b0, ADD, 1'b0, 1'b0, E_FETCH_WT);
    step("add_fetch",      1'b0, ADD, 1'b0, 1'b1, E_FETCH);
    step("add_decode",     1'b0, ADD, 1'b0, 1'b1, E_DEC);
    step("add_exr",        1'b0, ADD, 1'b0, 1'b1, E_EXR);
    step("add_wbr",        1'b0, ADD, 1'b0, 1'b1, E_WBR);
    expRet++;

    // ORR, another R-format.
    step("orr_fetch",  1'b0, ORR, 1'b0, 1'b1, E_FETCH);
    step("orr_decode", 1'b0, ORR, 1'b0, 1'b1, E_DEC);
    step("orr_exr",    1'b0, ORR, 1'b0, 1'b1, E_EXR);
    step("orr_wbr",    1'b0, ORR, 1'b0, 1'b1, E_WBR);
    expRet++;

    // LDUR with two memory wait states: seven cycles.
    step("ld_fetch",  1'b0, LDUR, 1'b0, 1'b1, E_FETCH);
    step("ld_decode", 1'b0, LDUR, 1'b0, 1'b1, E_DEC);
    step("ld_exaddr", 1'b0, LDUR, 1'b0, 1'b1, E_EXADDR);
    step("ld_memrd0", 1'b0, LDUR, 1'b0, 1'b0, E_MEMRD);
    step("ld_memrd1", 1'b0, LDUR, 1'b0, 1'b0, E_MEMRD);
    step("ld_memrd2", 1'b0, LDUR, 1'b0, 1'b1, E_MEMRD);
    step("ld_wbld",   1'b0, LDUR, 1'b0, 1'b1, E_WBLD);
    expRet++;

    // STUR; opcode garbage during fetch must not matter.
    step("st_fetch",  1'b0, ILL,  1'b0, 1'b1, E_FETCH);
    step("st_decode", 1'b0, STUR, 1'b0, 1'b1, E_DEC_R2L);
    step("st_exaddr", 1'b0, STUR, 1'b0, 1'b1, E_EXADDR);
    step("st_memwr",  1'b0, STUR, 1'b0, 1'b1, E_MEMWR);
    expRet++;

    // CBZ taken, then not taken.
    step("cbz1_fetch",  1'b0, CBZ, 1'b1, 1'b1, E_FETCH);
    step("cbz1_decode", 1'b0, CBZ, 1'b1, 1'b1, E_DEC_R2L);
    step("cbz1_br",     1'b0, CBZ, 1'b1, 1'b1, E_BR_T);
    expRet++;
    step("cbz0_fetch",  1'b0, CBZ, 1'b0, 1'b1, E_FETCH);
    step("cbz0_decode", 1'b0, CBZ, 1'b0, 1'b1, E_DEC_R2L);
    step("cbz0_br",     1'b0, CBZ, 1'b0, 1'b1, E_BR_N);
    expRet++;

    // Reset during a stalled store.
    step("rst_st_fetch",  1'b0, STUR, 1'b0, 1'b1, E_FETCH);
    step("rst_st_decode", 1'b0, STUR, 1'b0, 1'b1, E_DEC_R2L);
    step("rst_st_exaddr", 1'b0, STUR, 1'b0, 1'b1, E_EXADDR);
    step("rst_st_memwr",  1'b0, STUR, 1'b0, 1'b0, E_MEMWR);
    step("rst_st_reset",  1'b1, STUR, 1'b0, 1'b0, E_NONE);
    expRet = 0;

    // Illegal opcode traps; the trap ignores inputs until reset.
    step("ill_fetch",  1'b0, ADD, 1'b0, 1'b1, E_FETCH);
    step("ill_decode", 1'b0, ILL, 1'b0, 1'b1, E_DEC);
    for (int i = 0; i < 10; i++) begin
      step("trap_hold", 1'b0, (i % 2 == 0) ? CBZ : ADD, 1'b1, 1'(i % 2), E_TRAP);
    end
    step("trap_reset", 1'b1, ADD, 1'b1, 1'b1, E_TRAP);

    // Sixteen retirements wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) begin
      step("wrap_fetch",  1'b0, CBZ, 1'b0, 1'b1, E_FETCH);
      step("wrap_decode", 1'b0, CBZ, 1'b0, 1'b1, E_DEC_R2L);
      step("wrap_br",     1'b0, CBZ, 1'b0, 1'b1, E_BR_N);
      expRet = (expRet + 1) % (1 << CNT_W);
    end
    step("wrap_final", 1'b0, ADD, 1'b0, 1'b0, E_FETCH_WT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
